// File: rtl/keccak_round_scheduler.sv
// keccak_round_scheduler: sequences theta/rho/pi/chi/iota units
// through NROUNDS rounds of one Keccak-f permutation.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   start, abort      launch a permutation / return to idle
//   *Done             completion pulses from the five step units
//   go_*              one-cycle launch pulses to the step units
//   round_idx         current round (also the iota RC index)
//   step              0 idle,1-5 theta..iota,6 done,7 error
//   busy, done, err   status flags
module keccak_round_scheduler #(
    parameter int NROUNDS = 24,
    parameter int TIMEOUT = 131072
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       colparDone,
    input  logic       rotDone,
    input  logic       permDone,
    input  logic       revalDone,
    input  logic       addRCDone,
    output logic       go_colpar,
    output logic       go_rotate,
    output logic       go_permut,
    output logic       go_reval,
    output logic       go_addRC,
    output logic [4:0] round_idx,
    output logic [2:0] step,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_THETA = 3'd1;
    localparam logic [2:0] S_RHO   = 3'd2;
    localparam logic [2:0] S_PI    = 3'd3;
    localparam logic [2:0] S_CHI   = 3'd4;
    localparam logic [2:0] S_IOTA  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [4:0]  LAST_RND = 5'(NROUNDS - 1);
    localparam logic [16:0] WD_MAX   = 17'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [16:0] wd_q, wd_d;
    logic [4:0]  go_q, go_d;
    logic        acc;
    logic        expire;
    logic        entry;
    logic        step_d;

    // Only the done input owned by the current step counts.
    always_comb begin
        acc = 1'b0;
        unique case (state_q)
            S_THETA: acc = colparDone;
            S_RHO:   acc = rotDone;
            S_PI:    acc = permDone;
            S_CHI:   acc = revalDone;
            S_IOTA:  acc = addRCDone;
            default: acc = 1'b0;
        endcase
    end

    // A done coinciding with expiry wins.
    assign expire = (wd_q == WD_MAX) && !acc;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        if (abort) begin
            state_d = S_IDLE;
            rnd_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_d = S_THETA;
                        rnd_d   = '0;
                    end
                end
                S_THETA, S_RHO, S_PI, S_CHI: begin
                    if (acc) begin
                        state_d = state_q + 3'd1;
                    end else if (expire) begin
                        state_d = S_ERR;
                    end
                end
                S_IOTA: begin
                    if (acc) begin
                        if (rnd_q == LAST_RND) begin
                            state_d = S_DONE;
                        end else begin
                            rnd_d   = rnd_q + 5'd1;
                            state_d = S_THETA;
                        end
                    end else if (expire) begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign entry  = (state_d != state_q);
    assign step_d = (state_d != S_IDLE) && (state_d < S_DONE);

    // Watchdog restarts on every step entry and saturates.
    always_comb begin
        wd_d = '0;
        if (step_d && !entry) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + 17'd1;
        end
    end

    // Launch pulse for the step being entered; bit0 = theta.
    always_comb begin
        go_d = '0;
        if (entry && step_d) begin
            go_d = 5'd1 << (state_d - 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            wd_q    <= '0;
            go_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            wd_q    <= wd_d;
            go_q    <= go_d;
        end
    end

    assign go_colpar = go_q[0];
    assign go_rotate = go_q[1];
    assign go_permut = go_q[2];
    assign go_reval  = go_q[3];
    assign go_addRC  = go_q[4];
    assign round_idx = rnd_q;
    assign step      = state_q;
    assign busy      = (state_q != S_IDLE) && (state_q < S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// tb_keccak_round_scheduler: scoreboard bench with randomized
// unit latencies for keccak_round_scheduler.
module tb_keccak_round_scheduler;

    localparam int NR = 24;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] resp = '0;
    logic [4:0] stray = '0;
    logic       go_colpar, go_rotate, go_permut;
    logic       go_reval, go_addRC;
    logic [4:0] round_idx;
    logic [2:0] step;
    logic       busy, done, err;
    logic [4:0] gov;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int lat_mode = 1;
    int wk = -1;
    int wr = -1;

    assign gov = {go_addRC, go_reval, go_permut,
                  go_rotate, go_colpar};

    always #5 clk = ~clk;

    keccak_round_scheduler #(
        .NROUNDS(NR),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .colparDone(resp[0] | stray[0]),
        .rotDone(resp[1] | stray[1]),
        .permDone(resp[2] | stray[2]),
        .revalDone(resp[3] | stray[3]),
        .addRCDone(resp[4] | stray[4]),
        .go_colpar(go_colpar),
        .go_rotate(go_rotate),
        .go_permut(go_permut),
        .go_reval(go_reval),
        .go_addRC(go_addRC),
        .round_idx(round_idx),
        .step(step),
        .busy(busy),
        .done(done),
        .err(err)
    );

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    // Expected events: unit*32+round for go pulses,
    // 5*32+round for done, 192 for the error entry.
    task automatic push_seq(input int last_r, input int last_k);
        for (int r = 0; r <= last_r; r++) begin
            for (int k = 0; k < 5; k++) begin
                if (r < last_r || k <= last_k) begin
                    exp_q.push_back(k * 32 + r);
                end
            end
        end
    endtask

    task automatic push_full();
        push_seq(NR - 1, 4);
        exp_q.push_back(5 * 32 + NR - 1);
    endtask

    task automatic pop_cmp(input string nm, input int ev);
        if (exp_q.size() == 0) begin
            chk({nm, "_unexpected"}, ev, -1);
        end else begin
            chk(nm, ev, exp_q.pop_front());
        end
    endtask

    task automatic wait_state(input int s, input int r,
                              input int budget,
                              input string nm,
                              output int n);
        n = 0;
        while (!(int'(step) == s &&
                 (r < 0 || int'(round_idx) == r)) &&
               n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (int'(step) == s &&
                 (r < 0 || int'(round_idx) == r)) ? 1 : 0, 1);
    endtask

    task automatic run_full(input string nm);
        int n;
        @(negedge clk);
        push_full();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(6, -1, 3000, nm, n);
        @(negedge clk);
    endtask

    // Counts negedges from the start request: done must
    // appear at exp_done, a theta every period cycles.
    task automatic timed_perm(input int lat, input int exp_done,
                              input int period,
                              input string nm);
        int k, gos, done_at, first_go, th;
        lat_mode = lat;
        @(negedge clk);
        push_full();
        start = 1'b1;
        k = 0;
        gos = 0;
        th = 0;
        done_at = -1;
        first_go = -1;
        while (k < 600 && done_at < 0) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                first_go = int'(gov);
            end
            gos += $countones(gov);
            if (gov[0] && ((k - 1) % period == 0)) th++;
            if (done) done_at = k;
        end
        chk({nm, "_first_go"}, first_go, 1);
        chk({nm, "_go_count"}, gos, 5 * NR);
        chk({nm, "_theta_cadence"}, th, NR);
        chk({nm, "_done_at"}, done_at, exp_done);
        @(negedge clk);
        chk({nm, "_done_1cyc"}, int'(done), 0);
        chk({nm, "_idle"}, int'(step), 0);
        chk({nm, "_round_hold"}, int'(round_idx), NR - 1);
    endtask

    // Unit models: each go is answered after a latency.
    initial begin
        int pend[5];
        for (int u = 0; u < 5; u++) pend[u] = -1;
        forever begin
            @(negedge clk);
            resp = '0;
            if (!rst) begin
                for (int u = 0; u < 5; u++) pend[u] = -1;
            end else begin
                for (int u = 0; u < 5; u++) begin
                    if (gov[u]) begin
                        pend[u] = (lat_mode < 0) ?
                            int'($urandom_range(0, 3)) : lat_mode;
                    end
                    if (pend[u] == 0) begin
                        if (!(u == wk && int'(round_idx) == wr))
                            resp[u] = 1'b1;
                        pend[u] = -1;
                    end else if (pend[u] > 0) begin
                        pend[u]--;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows
    // a go pulse, a done pulse or a fresh error entry.
    initial begin
        logic err_prev;
        int idx;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (gov != 5'd0) begin
                    chk("go_onehot", $countones(gov), 1);
                    idx = 0;
                    for (int u = 0; u < 5; u++)
                        if (gov[u]) idx = u;
                    pop_cmp("go_seq", idx * 32 + int'(round_idx));
                end
                if (done) begin
                    pop_cmp("done_seq", 5 * 32 + int'(round_idx));
                end
                if (err && !err_prev) begin
                    pop_cmp("err_seq", 192);
                end
                err_prev = err;
            end else begin
                err_prev = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, k;
        #12;
        chk("rst_step", int'(step), 0);
        chk("rst_round", int'(round_idx), 0);
        chk("rst_go", int'(gov), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        timed_perm(1, 241, 10, "nom");
        timed_perm(0, 121, 5, "zero");

        // Start while busy and a stray rotDone in theta.
        lat_mode = -1;
        @(negedge clk);
        push_full();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(1, 5, 2000, "busy_reach", n);
        start = 1'b1;
        stray = 5'b00010;
        @(negedge clk);
        start = 1'b0;
        stray = '0;
        wait_state(6, -1, 3000, "busy_done", n);
        @(negedge clk);

        // Withhold permDone in round 3 to trip the watchdog.
        wk = 2;
        wr = 3;
        @(negedge clk);
        push_seq(3, 2);
        exp_q.push_back(192);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(3, 3, 2000, "to_reach_pi", n);
        k = 0;
        while (!err && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", k, TO);
        chk("to_err", int'(err), 1);
        chk("to_step", int'(step), 7);
        chk("to_busy", int'(busy), 0);
        wk = -1;
        repeat (3) @(negedge clk);
        chk("to_err_hold", int'(err), 1);
        push_full();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_err", int'(err), 0);
        chk("restart_round", int'(round_idx), 0);
        chk("restart_go", int'(gov), 1);
        wait_state(6, -1, 3000, "restart_done", n);
        @(negedge clk);

        // Abort in chi of round 10 together with revalDone.
        wk = 3;
        wr = 10;
        @(negedge clk);
        push_seq(10, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(4, 10, 2000, "ab_reach", n);
        abort = 1'b1;
        stray = 5'b01000;
        @(negedge clk);
        abort = 1'b0;
        stray = '0;
        chk("ab_step", int'(step), 0);
        chk("ab_round", int'(round_idx), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_go", int'(gov), 0);
        wk = -1;
        repeat (3) @(negedge clk);
        chk("ab_q_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of rho.
        @(negedge clk);
        push_full();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(2, 0, 200, "mr_reach", n);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_step", int'(step), 0);
        chk("mr_round", int'(round_idx), 0);
        chk("mr_go", int'(gov), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_err", int'(err), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_stay_idle", int'(step), 0);
        chk("mr_stay_busy", int'(busy), 0);

        repeat (3) run_full("rand_done");
        chk("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
